// File: rtl/pi_hsk_pkg.sv
// Shared types and defaults for the Raspberry Pi PMOD word receiver.
// The optional partial-word timeout is enabled by the HSK_TIMEOUT_EN macro (see pi_hsk_word_rx).
package pi_hsk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hsk_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_BEATS       = 4;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;

    function automatic int fifo_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pi_hsk_fifo.sv
// Show-ahead word FIFO: head entry is presented combinationally, zero when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module pi_hsk_fifo
    import pi_hsk_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W * DEF_BEATS,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    input  logic                            pop,
    output logic [WIDTH-1:0]                pop_data,
    output logic                            full,
    output logic                            empty,
    output logic [fifo_count_w(DEPTH)-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = fifo_count_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pi_hsk_word_rx.sv
// Pi PMOD receive front-end: strobe synchroniser, 4-phase req/ack FSM, beat assembly into a word FIFO.
// Define HSK_TIMEOUT_EN to discard a partial word after TIMEOUT_CYC idle cycles.
//
//   state | meaning
//   IDLE  | fpga_hsk low, waiting for synchronised request and room for the beat
//   ACK   | fpga_hsk high, beat captured, waiting for the Pi to drop its request
module pi_hsk_word_rx
    import pi_hsk_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int BEATS       = DEF_BEATS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pi_hsk_raw,
    input  logic [DATA_W-1:0]                    pmod_data,
    output logic                                 fpga_hsk,
    output logic [DATA_W*BEATS-1:0]              word_data,
    output logic                                 word_valid,
    input  logic                                 word_ready,
    output logic [fifo_count_w(FIFO_DEPTH)-1:0]  fifo_count,
    output logic                                 timeout_err
);

    localparam int WORD_W = DATA_W * BEATS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hsk_s;
    hsk_state_t             state;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [WORD_W-1:0]      asm_q;
    logic [WORD_W-1:0]      asm_next;
    logic                   last_beat;
    logic                   capture;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   tmo_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pi_hsk_raw};
        end
    end

    assign hsk_s     = sync_q[SYNC_STAGES-1];
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
    // The last beat is only acknowledged when the word has somewhere to go.
    assign capture   = (state == IDLE) && hsk_s && (!last_beat || !fifo_full);
    assign push      = capture && last_beat;

    always_comb begin
        asm_next = asm_q;
        asm_next[beat_cnt*DATA_W +: DATA_W] = pmod_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fpga_hsk <= 1'b0;
            beat_cnt <= '0;
            asm_q    <= '0;
        end else if (capture) begin
            state    <= ACK;
            fpga_hsk <= 1'b1;
            asm_q    <= asm_next;
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end else if (state == ACK && !hsk_s) begin
            state    <= IDLE;
            fpga_hsk <= 1'b0;
        end else if (tmo_fire) begin
            beat_cnt <= '0;
        end
    end

`ifdef HSK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_run;

    assign tmo_run  = (state == IDLE) && (beat_cnt != '0) && !hsk_s;
    assign tmo_fire = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_fire;
            if (capture || tmo_fire) begin
                tmo_cnt <= '0;
            end else if (tmo_run) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign tmo_fire       = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    pi_hsk_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (asm_next),
        .pop       (word_ready),
        .pop_data  (word_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign word_valid = !fifo_empty;

endmodule

// File: tb/tb_pi_hsk_word_rx.sv
// Directed bench for pi_hsk_word_rx (DATA_W=8, BEATS=4, FIFO_DEPTH=4, SYNC_STAGES=2).
// Optional timeout section runs when HSK_TIMEOUT_EN is defined.
module tb_pi_hsk_word_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        pi_hsk_raw;
    logic [7:0]  pmod_data;
    logic        fpga_hsk;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_count;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pi_hsk_word_rx #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .BEATS       (4),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pi_hsk_raw  (pi_hsk_raw),
        .pmod_data   (pmod_data),
        .fpga_hsk    (fpga_hsk),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [7:0]  b [4];
        logic [31:0] exp_word;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_up(input logic [7:0] d, input int limit, output int lat);
        pmod_data  = d;
        pi_hsk_raw = 1'b1;
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (fpga_hsk) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic beat_down(output int lat);
        pi_hsk_raw = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (!fpga_hsk) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic send_beat(input logic [7:0] d);
        int lat;
        beat_up(d, 10, lat);
        check("ack_latency", lat, 3);
        beat_down(lat);
        check("release_latency", lat, 3);
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
    endtask

    vec_t vecs [4];
    int   lat;
    int   pulses;
    int   waited;

    initial begin
        vecs[0].b = '{8'h11, 8'h22, 8'h33, 8'h44}; vecs[0].exp_word = 32'h4433_2211;
        vecs[1].b = '{8'h00, 8'hFF, 8'h00, 8'hFF}; vecs[1].exp_word = 32'hFF00_FF00;
        vecs[2].b = '{8'hA5, 8'h5A, 8'hC3, 8'h3C}; vecs[2].exp_word = 32'h3CC3_5AA5;
        vecs[3].b = '{8'h01, 8'h02, 8'h03, 8'h04}; vecs[3].exp_word = 32'h0403_0201;

        reset      = 1'b1;
        pi_hsk_raw = 1'b0;
        pmod_data  = 8'h00;
        word_ready = 1'b0;
        tick();

        // Reset held while the strobe toggles: nothing may leak out.
        for (int i = 0; i < 6; i++) begin
            pi_hsk_raw = ~pi_hsk_raw;
            tick();
        end
        check("rst_fpga_hsk", fpga_hsk, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_word_data", word_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Strobe held through release: captured as beat 0 after the synchroniser.
        pi_hsk_raw = 1'b1;
        pmod_data  = 8'hAA;
        reset      = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("post_rst_ack_timing", fpga_hsk, (i == 3) ? 1 : 0);
        end
        beat_down(lat);
        check("post_rst_release", lat, 3);
        send_beat(8'hBB);
        send_beat(8'hCC);
        send_beat(8'hDD);
        check("post_rst_word", word_data, 32'hDDCC_BBAA);
        pop_one();
        check("post_rst_drained", fifo_count, 0);

        // Table-driven word assembly.
        for (int v = 0; v < 4; v++) begin
            for (int b = 0; b < 3; b++) send_beat(vecs[v].b[b]);
            check("valid_before_last", word_valid, 0);
            beat_up(vecs[v].b[3], 10, lat);
            check("last_ack_latency", lat, 3);
            check("valid_after_last", word_valid, 1);
            check("word_data", word_data, vecs[v].exp_word);
            check("count_one", fifo_count, 1);
            beat_down(lat);
            pop_one();
            check("count_after_pop", fifo_count, 0);
            check("data_after_pop", word_data, 0);
        end

        // Backpressure: four words fill the FIFO, the fifth word's last beat stalls.
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (w == 4 && b == 3) break;
                send_beat(8'(w * 16 + b));
            end
        end
        check("bp_full_count", fifo_count, 4);
        beat_up(8'h43, 10, lat);
        check("bp_no_ack", lat, -1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("bp_pop_count", fifo_count, 3);
        check("bp_deferred_push", fpga_hsk, 0);
        lat = -1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (fpga_hsk) begin
                lat = i;
                break;
            end
        end
        check("bp_release_latency", lat, 2);
        check("bp_refill_count", fifo_count, 4);
        beat_down(lat);
        for (int w = 1; w < 5; w++) begin
            check("bp_drain_valid", word_valid, 1);
            check("bp_drain_data", word_data,
                  {8'(w * 16 + 3), 8'(w * 16 + 2), 8'(w * 16 + 1), 8'(w * 16)});
            pop_one();
        end
        check("bp_drained", word_valid, 0);

        // Simultaneous push and pop with two words queued.
        for (int b = 0; b < 4; b++) send_beat(8'hA0 + 8'(b));
        for (int b = 0; b < 4; b++) send_beat(8'hB0 + 8'(b));
        for (int b = 0; b < 3; b++) send_beat(8'hC0 + 8'(b));
        check("pp_count_before", fifo_count, 2);
        pmod_data  = 8'hC3;
        pi_hsk_raw = 1'b1;
        tick();
        tick();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("pp_ack", fpga_hsk, 1);
        check("pp_count_same", fifo_count, 2);
        beat_down(lat);
        check("pp_head_b", word_data, 32'hB3B2_B1B0);
        pop_one();
        check("pp_head_c", word_data, 32'hC3C2_C1C0);
        pop_one();
        check("pp_empty", fifo_count, 0);

        // Partial word followed by a long idle.
        send_beat(8'h51);
        send_beat(8'h52);
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (timeout_err) pulses++;
        end
`ifdef HSK_TIMEOUT_EN
        check("tmo_pulses", pulses, 1);
        check("tmo_fifo_untouched", fifo_count, 0);
        for (int b = 0; b < 4; b++) send_beat(8'h61 + 8'(b));
        check("tmo_clean_word", word_data, 32'h6463_6261);
`else
        check("tmo_disabled_pulses", pulses, 0);
        send_beat(8'h53);
        send_beat(8'h54);
        check("tmo_disabled_word", word_data, 32'h5453_5251);
`endif
        pop_one();
        check("tmo_drained", fifo_count, 0);

        // Mid-word reset discards the partial word.
        send_beat(8'h77);
        send_beat(8'h88);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_hsk", fpga_hsk, 0);
        for (int b = 0; b < 4; b++) send_beat(8'h01 + 8'(b));
        check("mid_rst_word", word_data, 32'h0403_0201);
        check("mid_rst_valid", word_valid, 1);
        pop_one();

        waited = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
